mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage placed directly downstream of the execute stage. It takes the ALU result, rs2 store data, funct3 and destination info, and performs RISC-V LB/LH/LW/LBU/LHU and SB/SH/SW against an internal byte-addressable, synchronous-read data memory. It produces a registered writeback bundle for the writeback stage. Loads take two cycles; a stall output holds upstream during the second cycle.

## Interface
Parameters:
- DEPTH_WORDS, 1024: data memory size in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0100_0000: byte address mapped to word 0.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  execute result present this cycle.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  load/store width and sign.
- addr  in  32  ALU result: effective address for loads/stores, and passthrough value otherwise.
- store_data  in  32  rs2 value.
- rd  in  5  destination register.
- reg_wen  in  1  instruction writes rd.
- stall  out  1  high while a load is in LOAD_WAIT; upstream must hold its inputs.
- wb_valid  out  1  writeback bundle valid (registered).
- wb_rd  out  5  registered destination.
- wb_wen  out  1  registered register-write enable.
- wb_data  out  32  registered writeback value.
- misaligned  out  1  registered, coincident with wb_valid; access was misaligned.

## Operation
- Word index = ((addr − BASE_ADDR) >> 2) mod DEPTH_WORDS, so out-of-range addresses wrap. Byte offset = addr[1:0].
- Alignment:
  - SH/LH/LHU are misaligned when addr[0]=1.
  - SW/LW are misaligned when addr[1:0]≠0.
  - A misaligned access performs no memory read or write, and returns wb_wen=0 and misaligned=1.
- FSM states: IDLE and LOAD_WAIT.
- In IDLE with in_valid=1:
  - Non-memory instruction: capture wb_data=addr and wb_wen=reg_wen; stay in IDLE.
  - Store (mem_write=1, mem_read=0):
    - Write enables by funct3[1:0]: 00 writes store_data[7:0] to byte offset; 01 writes store_data[15:0] to halfword offset; 10 writes the full word; 11 writes nothing.
    - Bytes not enabled are unchanged.
    - Writeback bundle: wb_wen=0, wb_data=addr.
  - Aligned load: latch funct3, byte offset, rd and reg_wen; register the memory word (synchronous read); go to LOAD_WAIT. Emit no writeback this edge.
  - Misaligned load: writeback bundle with wb_wen=0, misaligned=1; stay in IDLE.
  - mem_read and mem_write both high: treat as a load; no write occurs.
- In LOAD_WAIT:
  - Inputs are ignored.
  - Extract the result from the registered word and latched offset:
    - 000 LB and 001 LH sign-extend.
    - 100 LBU and 101 LHU zero-extend.
    - 010, 011, 110 and 111 return the full word.
  - Capture wb_data, wb_rd, and wb_wen=latched reg_wen; return to IDLE.
- in_valid=0 in IDLE: wb_valid=0 next cycle. Other wb_* fields hold their previous values.
- Reset:
  - Outputs after reset: state=IDLE, wb_valid=0, wb_rd=0, wb_wen=0, wb_data=0, misaligned=0, stall=0.
  - Reset asserted in LOAD_WAIT aborts the load; no writeback is produced.
  - Memory contents are not cleared by reset.

## Timing
- stall is combinational: stall = (state == LOAD_WAIT).
- Non-load accepted at edge N → wb_valid=1 in cycle N+1, for one cycle.
- Load accepted at edge N → stall=1 throughout cycle N+1 → wb_valid=1 in cycle N+2. Upstream must present a new instruction only from cycle N+2.
- Store at edge N followed by a load of the same word at edge N+1: the load returns the newly written data (no bypass needed).
- Back-to-back loads: each costs two cycles. wb_valid pattern is 0,1,0,1.
- wb_valid is never high in two consecutive cycles for a load.

## Test plan
- Reset with all inputs at 0 → all outputs 0, stall=0. Then an ALU op with addr=32'h0000_0005, rd=3, reg_wen=1 → next cycle: wb_valid=1, wb_rd=3, wb_data=5, wb_wen=1.
- SW 32'h8081_F0F1 to BASE_ADDR, then:
  - LB at BASE_ADDR+0 → wb_data=32'hFFFF_FFF1, two cycles after accept.
  - LBU at +1 → 32'h0000_00F0.
  - LH at +2 → 32'hFFFF_8081.
  - LHU at +2 → 32'h0000_8081.
- SB 32'h0000_00AA to BASE_ADDR+3 over word 32'h1122_3344, then LW → 32'hAA22_3344. Also check stall=1 for exactly one cycle.
- Misaligned accesses:
  - LW at BASE_ADDR+2 → misaligned=1, wb_wen=0, no stall.
  - SH at BASE_ADDR+1 → misaligned=1 and memory unchanged, confirmed by a subsequent LW.
- Load to BASE_ADDR + 4·DEPTH_WORDS → returns word 0 (wrap). Store with funct3=011 → memory unchanged.
- Accept a load, then assert reset in the LOAD_WAIT cycle → no wb_valid; next cycle state is IDLE with stall=0; memory contents are preserved.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: RISC-V byte/half/word loads and stores against a
// synchronous-read data memory, producing a registered writeback bundle.
// Loads take two cycles; stall holds upstream during the second one.
module mem_stage #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        reg_wen,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic [31:0] wb_data,
    output logic        misaligned
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic [31:0]      rdata_q;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;
    logic             mem_re;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic             access_misaligned;
    logic [31:0]      ld_result;

    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic        ld_wen_q, ld_wen_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_wen_q, wb_wen_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_mis_q, wb_mis_d;

    // Out-of-range addresses wrap onto the memory
    assign mem_idx = IDX_W'((addr - BASE_ADDR) >> 2);

    assign stall      = (state_q == LOAD_WAIT);
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_wen     = wb_wen_q;
    assign wb_data    = wb_data_q;
    assign misaligned = wb_mis_q;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0
    always_comb begin
        access_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   access_misaligned = addr[0];
            2'b10:   access_misaligned = (addr[1:0] != 2'b00);
            default: access_misaligned = 1'b0;
        endcase
    end

    // Extract and extend the load result from the registered word
    always_comb begin
        logic [7:0]  ld_byte;
        logic [15:0] ld_half;
        case (ld_off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = ld_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (ld_f3_q)
            3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_result = {24'd0, ld_byte};
            3'b101:  ld_result = {16'd0, ld_half};
            default: ld_result = rdata_q;
        endcase
    end

    // Next-state, writeback bundle and memory control
    always_comb begin
        state_d    = state_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        ld_rd_d    = ld_rd_q;
        ld_wen_d   = ld_wen_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_wen_d   = wb_wen_q;
        wb_data_d  = wb_data_q;
        wb_mis_d   = wb_mis_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_be     = 4'b0000;
        mem_wdata  = store_data;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_read) begin
                        if (access_misaligned) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = rd;
                            wb_wen_d   = 1'b0;
                            wb_data_d  = addr;
                            wb_mis_d   = 1'b1;
                        end else begin
                            mem_re   = 1'b1;
                            ld_f3_d  = funct3;
                            ld_off_d = addr[1:0];
                            ld_rd_d  = rd;
                            ld_wen_d = reg_wen;
                            state_d  = LOAD_WAIT;
                        end
                    end else if (mem_write) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_wen_d   = 1'b0;
                        wb_data_d  = addr;
                        wb_mis_d   = access_misaligned;
                        if (!access_misaligned) begin
                            mem_we = 1'b1;
                            case (funct3[1:0])
                                2'b00: begin
                                    mem_be    = 4'b0001 << addr[1:0];
                                    mem_wdata = {4{store_data[7:0]}};
                                end
                                2'b01: begin
                                    mem_be    = addr[1] ? 4'b1100 : 4'b0011;
                                    mem_wdata = {2{store_data[15:0]}};
                                end
                                2'b10:   mem_be = 4'b1111;
                                default: mem_be = 4'b0000;
                            endcase
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_wen_d   = reg_wen;
                        wb_data_d  = addr;
                        wb_mis_d   = 1'b0;
                    end
                end
            end
            LOAD_WAIT: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ld_rd_q;
                wb_wen_d   = ld_wen_q;
                wb_data_d  = ld_result;
                wb_mis_d   = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, load context and writeback registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ld_f3_q    <= 3'd0;
            ld_off_q   <= 2'd0;
            ld_rd_q    <= 5'd0;
            ld_wen_q   <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_wen_q   <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
            ld_rd_q    <= ld_rd_d;
            ld_wen_q   <= ld_wen_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wen_q   <= wb_wen_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
        end
    end

    // Byte-enabled data memory with registered read; contents survive reset
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (mem_re) begin
            rdata_q <= mem_q[mem_idx];
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-array reference model predicts each
// writeback bundle; a negedge monitor pops and compares on every wb_valid.
module tb_mem_stage;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, mem_read, mem_write, reg_wen;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd;
    logic        stall, wb_valid, wb_wen, misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
        logic        mis;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mdl [4*DEPTH];
    int         n_assert = 0;
    int         n_fail   = 0;

    mem_stage #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .rd(rd), .reg_wen(reg_wen), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_wen(wb_wen), .wb_data(wb_data), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: predicts the writeback bundle and updates byte memory
    task automatic model(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic w, output bit waits);
        exp_t        e;
        int unsigned wbase;
        int unsigned off;
        int          nbytes;
        logic [31:0] val;
        bit          mis;
        wbase  = (((a - BASE) >> 2) % DEPTH) * 4;
        off    = int'(a[1:0]);
        mis    = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        waits  = 1'b0;
        e.rd   = r;
        e.wen  = 1'b0;
        e.data = a;
        e.mis  = mis;
        if (mr) begin
            if (!mis) begin
                waits = 1'b1;
                val   = 32'd0;
                if (nbytes == 4) begin
                    for (int i = 0; i < 4; i++) val[8*i +: 8] = mdl[wbase + i];
                end else begin
                    for (int i = 0; i < nbytes; i++) val[8*i +: 8] = mdl[wbase + off + i];
                    if (!f3[2]) begin
                        if (nbytes == 1) val = {{24{val[7]}}, val[7:0]};
                        else             val = {{16{val[15]}}, val[15:0]};
                    end
                end
                e.wen  = w;
                e.data = val;
            end
        end else if (mw) begin
            if (!mis && f3[1:0] != 2'd3) begin
                for (int i = 0; i < nbytes; i++)
                    mdl[wbase + ((nbytes == 4) ? 0 : off) + i] = sd[8*i +: 8];
            end
        end else begin
            e.wen = w;
            e.mis = 1'b0;
        end
        if (!waits || mr) exp_q.push_back(e);
    endtask

    // Issue one instruction; for loads, fill the stall cycle with random noise
    task automatic issue(input logic v, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input logic w);
        bit waits;
        @(negedge clk);
        in_valid = v; mem_read = mr; mem_write = mw; funct3 = f3;
        addr = a; store_data = sd; rd = r; reg_wen = w;
        waits = 1'b0;
        if (v) model(mr, mw, f3, a, sd, r, w, waits);
        @(posedge clk);
        #1;
        chk("stall_after_accept", 32'(stall), 32'(waits));
        if (waits) begin
            @(negedge clk);
            in_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
            rd = 5'($urandom); reg_wen = 1'($urandom);
            @(posedge clk);
            #1;
            chk("stall_released", 32'(stall), 32'd0);
        end
    endtask

    // Monitor: every wb_valid must match the oldest prediction
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_wb: wb_valid=1 with no pending expectation at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_wen", 32'(wb_wen), 32'(e.wen));
                chk("wb_data", wb_data, e.data);
                chk("misaligned", 32'(misaligned), 32'(e.mis));
            end
        end
    end

    initial begin
        int waitc;
        reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; rd = 5'd0; reg_wen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_wen", 32'(wb_wen), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU passthrough
        issue(1, 0, 0, 3'd0, 32'h0000_0005, 32'd0, 5'd3, 1);

        // Fill memory so every location is defined
        for (int i = 0; i < int'(DEPTH); i++)
            issue(1, 0, 1, 3'b010, BASE + 32'(4 * i), $urandom, 5'($urandom), 1);

        // Sub-word loads of a known word
        issue(1, 0, 1, 3'b010, BASE, 32'h8081_F0F1, 5'd1, 0);
        issue(1, 1, 0, 3'b000, BASE + 0, 32'd0, 5'd4, 1);
        issue(1, 1, 0, 3'b100, BASE + 1, 32'd0, 5'd5, 1);
        issue(1, 1, 0, 3'b001, BASE + 2, 32'd0, 5'd6, 1);
        issue(1, 1, 0, 3'b101, BASE + 2, 32'd0, 5'd7, 1);

        // Byte store merges into existing word
        issue(1, 0, 1, 3'b010, BASE + 4, 32'h1122_3344, 5'd1, 0);
        issue(1, 0, 1, 3'b000, BASE + 7, 32'h0000_00AA, 5'd1, 0);
        issue(1, 1, 0, 3'b010, BASE + 4, 32'd0, 5'd8, 1);

        // Misaligned load and store
        issue(1, 1, 0, 3'b010, BASE + 2, 32'd0, 5'd9, 1);
        issue(1, 0, 1, 3'b001, BASE + 1, 32'hDEAD_BEEF, 5'd9, 1);
        issue(1, 1, 0, 3'b010, BASE, 32'd0, 5'd10, 1);

        // Address wrap, funct3=011 store, load+store both high
        issue(1, 1, 0, 3'b010, BASE + 32'(4 * DEPTH), 32'd0, 5'd11, 1);
        issue(1, 0, 1, 3'b011, BASE + 8, 32'hCAFE_F00D, 5'd12, 1);
        issue(1, 1, 0, 3'b010, BASE + 8, 32'd0, 5'd12, 1);
        issue(1, 1, 1, 3'b010, BASE + 12, 32'h5555_AAAA, 5'd13, 1);
        issue(1, 1, 0, 3'b010, BASE + 12, 32'd0, 5'd13, 1);

        // Reset during LOAD_WAIT aborts the load without a writeback
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr = BASE + 4; rd = 5'd14; reg_wen = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_stall_high", 32'(stall), 32'd1);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_stall_low", 32'(stall), 32'd0);
        chk("abort_no_wb", 32'(wb_valid), 32'd0);
        chk("abort_wb_data", wb_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(1, 1, 0, 3'b010, BASE + 4, 32'd0, 5'd14, 1);

        // Randomized mix, addresses spanning two wraps of the memory
        for (int n = 0; n < 300; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 3);
            issue(1'($urandom_range(0, 7) != 0), kind == 1 || kind == 3, kind == 2 || kind == 3,
                  3'($urandom), (kind == 0) ? $urandom : BASE + $urandom_range(0, 8 * DEPTH - 1),
                  $urandom, 5'($urandom), 1'($urandom));
        end

        @(negedge clk);
        in_valid = 1'b0;
        waitc = 0;
        while (exp_q.size() != 0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d writebacks still pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
